// File: rtl/bf16_mul_finalize.sv
// bfloat16 multiply finalisation: sign/exponent, special operands, overflow/underflow, 2-stage valid/ready.
// Optional `FMUL_SAT_EN: arithmetic overflow saturates to the largest finite magnitude instead of Inf.
module bf16_mul_finalize #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 7,
   parameter int BIAS  = 127
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic                   Xs,
   input  logic                   Ys,
   input  logic [EXP_W-1:0]       Xe,
   input  logic [EXP_W-1:0]       Ye,
   input  logic                   x_man_nz,
   input  logic                   y_man_nz,
   input  logic [MAN_W-1:0]       Zm,
   input  logic                   PM15,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [EXP_W+MAN_W:0]   Z,
   output logic                   ovf,
   output logic                   unf,
   output logic                   nan,
   input  logic                   clr_flags,
   output logic                   ovf_sticky,
   output logic                   unf_sticky,
   output logic                   nan_sticky
);
   localparam int EW = EXP_W + 2;
   localparam logic [EXP_W-1:0]        EXP_ONES = '1;
   localparam logic signed [EW-1:0]    E_OVF    = EW'(2**EXP_W - 1);

   logic adv1, adv2, out_xfer;

   logic                 s1_valid_q, s1_sign_q;
   logic [EW-1:0]        s1_exp_q, s1_exp_d;
   logic [MAN_W-1:0]     s1_man_q;
   logic                 s1_xz_q, s1_yz_q, s1_xinf_q, s1_yinf_q, s1_xnz_q, s1_ynz_q;

   logic                 out_valid_q;
   logic [EXP_W+MAN_W:0] z_q, z_d;
   logic                 ovf_q, ovf_d, unf_q, unf_d, nan_q, nan_d;
   logic                 ovf_st_q, unf_st_q, nan_st_q;

   logic signed [EW-1:0] e_s;
   logic                 nan_c, inf_c, zero_c;

   assign adv2     = !out_valid_q || out_ready;
   assign adv1     = !s1_valid_q || adv2;
   assign in_ready = adv1;
   assign out_xfer = out_valid_q && out_ready;

   // Two guard bits keep the unbiased sum exact so overflow and underflow classify correctly.
   assign s1_exp_d = EW'(Xe) + EW'(Ye) - EW'(BIAS) + EW'(PM15);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s1_sign_q  <= 1'b0;
         s1_exp_q   <= '0;
         s1_man_q   <= '0;
         s1_xz_q    <= 1'b0;
         s1_yz_q    <= 1'b0;
         s1_xinf_q  <= 1'b0;
         s1_yinf_q  <= 1'b0;
         s1_xnz_q   <= 1'b0;
         s1_ynz_q   <= 1'b0;
      end else if (adv1) begin
         s1_valid_q <= in_valid;
         if (in_valid) begin
            s1_sign_q <= Xs ^ Ys;
            s1_exp_q  <= s1_exp_d;
            s1_man_q  <= Zm;
            s1_xz_q   <= (Xe == '0);
            s1_yz_q   <= (Ye == '0);
            s1_xinf_q <= (Xe == EXP_ONES);
            s1_yinf_q <= (Ye == EXP_ONES);
            s1_xnz_q  <= x_man_nz;
            s1_ynz_q  <= y_man_nz;
         end
      end
   end

   assign e_s    = signed'(s1_exp_q);
   assign nan_c  = (s1_xinf_q && s1_xnz_q) || (s1_yinf_q && s1_ynz_q) ||
                   (s1_xinf_q && s1_yz_q)  || (s1_yinf_q && s1_xz_q);
   assign inf_c  = s1_xinf_q || s1_yinf_q;
   assign zero_c = s1_xz_q || s1_yz_q;

   always_comb begin
      z_d   = '0;
      ovf_d = 1'b0;
      unf_d = 1'b0;
      nan_d = 1'b0;
      if (nan_c) begin
         z_d   = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};
         nan_d = 1'b1;
      end else if (inf_c) begin
         z_d = {s1_sign_q, EXP_ONES, {MAN_W{1'b0}}};
      end else if (zero_c) begin
         z_d = {s1_sign_q, {(EXP_W+MAN_W){1'b0}}};
      end else if (e_s >= E_OVF) begin
`ifdef FMUL_SAT_EN
         z_d = {s1_sign_q, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
`else
         z_d = {s1_sign_q, EXP_ONES, {MAN_W{1'b0}}};
`endif
         ovf_d = 1'b1;
      end else if (e_s[EW-1] || (e_s == '0)) begin
         z_d   = {s1_sign_q, {(EXP_W+MAN_W){1'b0}}};
         unf_d = 1'b1;
      end else begin
         z_d = {s1_sign_q, s1_exp_q[EXP_W-1:0], s1_man_q};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         z_q         <= '0;
         ovf_q       <= 1'b0;
         unf_q       <= 1'b0;
         nan_q       <= 1'b0;
      end else if (adv2) begin
         out_valid_q <= s1_valid_q;
         if (s1_valid_q) begin
            z_q   <= z_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
            nan_q <= nan_d;
         end
      end
   end

   // Clear is applied first so a flag set by a transfer in the same cycle survives.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf_st_q <= 1'b0;
         unf_st_q <= 1'b0;
         nan_st_q <= 1'b0;
      end else begin
         ovf_st_q <= (ovf_st_q && !clr_flags) || (out_xfer && ovf_q);
         unf_st_q <= (unf_st_q && !clr_flags) || (out_xfer && unf_q);
         nan_st_q <= (nan_st_q && !clr_flags) || (out_xfer && nan_q);
      end
   end

   assign out_valid  = out_valid_q;
   assign Z          = z_q;
   assign ovf        = ovf_q;
   assign unf        = unf_q;
   assign nan        = nan_q;
   assign ovf_sticky = ovf_st_q;
   assign unf_sticky = unf_st_q;
   assign nan_sticky = nan_st_q;

endmodule
